dmem_bridge: RTL and testbench
==============================

# dmem_bridge

Data-side bridge between the single-cycle core's combinational data-memory port and a latency-tolerant valid/ready memory bus. It registers each core access, drives one bus transaction, and holds the core with `cpu_stall` until the write is accepted or the read data returns. It aligns read data to byte lane 0 so the core's load sign/zero-extension works unchanged. A watchdog aborts hung transactions.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in REQ+WAIT_R before abort; legal range 1..65535.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on timeout.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cpu_read` in 1: core load request.
- `cpu_write` in 4: core byte write enables, already lane-positioned.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: write data, already lane-positioned.
- `cpu_rdata` out 32: load data, shifted to lane 0.
- `cpu_stall` out 1: core must not advance while 1.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: request accepted when `bus_valid & bus_ready`.
- `bus_we` out 1: 1 = write.
- `bus_strb` out 4: byte strobes; 4'b1111 on reads.
- `bus_addr` out 32: word address, `{cpu_addr[31:2],2'b00}`.
- `bus_wdata` out 32: write data.
- `bus_rvalid` in 1: read response valid, single cycle.
- `bus_rdata` in 32: read response data.
- `err` out 1: sticky timeout flag.

## Operation
- States IDLE, REQ, WAIT_R, DONE.
- IDLE: request = `cpu_read | (|cpu_write)`. On request, latch addr/we/strb/wdata and byte offset `cpu_addr[1:0]`, go to REQ. `bus_rvalid` is ignored in IDLE.
- Write priority: if `cpu_write != 0`, the access is a write even when `cpu_read` = 1.
- REQ: `bus_valid` = 1 with stable latched fields until handshake. A write handshake goes to DONE. A read handshake goes to WAIT_R.
- WAIT_R: on `bus_rvalid`, capture `bus_rdata >> {off,3'b000}` (zero-filled) into the rdata register, go to DONE.
- DONE: `cpu_stall` = 0, and the core advances on this edge. Next state is IDLE unconditionally, so a request still presented in DONE is not reissued.
- Watchdog: a 16-bit counter clears on entry to REQ and counts each cycle in REQ/WAIT_R. When the count reaches `TIMEOUT_CYCLES`:
  - go to DONE and drop `bus_valid` (abort);
  - load `ERR_DATA` into rdata if the access is a read;
  - set `err`.
- `err` clears only on reset.
- `cpu_stall` = (state==IDLE & request) | state==REQ | state==WAIT_R. It is combinational from the core inputs in IDLE.
- `cpu_rdata` holds its last captured value outside DONE.

## Timing
- Reset values:
  - state IDLE
  - `bus_valid` 0, `bus_we` 0, `bus_strb` 0, `bus_addr` 0, `bus_wdata` 0
  - `cpu_rdata` 0, `err` 0, counter 0
  - `cpu_stall` follows the IDLE equation.
- Reset mid-transaction abandons it. A late `bus_rvalid` is then discarded in IDLE.
- Minimum write: request at cycle 0, REQ with ready at 1, DONE at 2. Stall is high in cycles 0–1.
- Minimum read: request at 0, handshake at 1, rvalid at 2, DONE at 3.
- `bus_rvalid` in the same cycle as the handshake is not legal bus behaviour and is ignored.
- Back-to-back accesses: with a new request already present, IDLE follows DONE. The next access issues at DONE+1.
- Timeout and response/handshake in the same cycle: the response/handshake wins and `err` is not set.

## Structure
- Package `dmem_bridge_pkg`: state enum (IDLE, REQ, WAIT_R, DONE), `ERR_DATA` default, counter width constant.
- One sub-module, `dmem_timeout`: clear/enable counter with an `expired` output.

## Test plan
- Write `cpu_write`=4'b0100, addr 0x102, wdata 0x00AB_0000, `bus_ready` high → one handshake: addr 0x100, strb 0100, we 1. Stall for 2 cycles, DONE at cycle 2.
- Byte read at addr 0x203, bus returns 0x8100_0000 after 3 wait cycles → `cpu_rdata` = 0x0000_0081 in DONE. Stall deasserts exactly in DONE.
- Request held through DONE → exactly one bus transaction; a second request issues at DONE+1.
- `cpu_read`=1 with `cpu_write`=4'b1111 → bus_we 1, no WAIT_R.
- `bus_ready` stuck low, `TIMEOUT_CYCLES`=4 → abort after 4 REQ cycles: `cpu_rdata` = 0xDEAD_BEEF, `err` = 1 until reset.
- Reset asserted in WAIT_R, then rvalid → state IDLE, `cpu_rdata` 0, response ignored.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          CNT_W            = 16;

    // Move the addressed byte lane down to lane 0, zero-filling the top.
    function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] off);
        return data >> {off, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_timeout.sv
// Watchdog counter for one bus transaction. expired is asserted in the
// cycle whose count would reach LIMIT, so the FSM leaves after exactly
// LIMIT enabled cycles.
module dmem_timeout
    import dmem_bridge_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Clear on transaction start, count while a transaction is outstanding.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

    assign expired = en && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Bridge from the core's combinational data port to a valid/ready bus.
// Each access is latched, issued as one bus transaction, and the core is
// stalled until the write is accepted, read data returns, or the watchdog
// aborts the access.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic [3:0]  cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [3:0]  bus_strb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        err
);

    state_t     state;
    state_t     state_next;
    logic       request;
    logic       accept;
    logic       handshake;
    logic       expired;
    logic       abort;
    logic [1:0] off_q;

    assign request   = cpu_read | (|cpu_write);
    assign accept    = (state == IDLE) && request;
    assign handshake = bus_valid && bus_ready;

    // A response or handshake in the expiry cycle takes precedence.
    assign abort = expired && (((state == REQ) && !handshake) ||
                               ((state == WAIT_R) && !bus_rvalid));

    dmem_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      ((state == REQ) || (state == WAIT_R)),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment up front keeps this block purely
        // combinational; a missing branch would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = REQ;
            REQ: begin
                if (handshake)
                    state_next = bus_we ? DONE : WAIT_R;
                else if (expired)
                    state_next = DONE;
            end
            WAIT_R:  if (bus_rvalid || expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; stall is combinational on the request in IDLE.
    always_comb begin
        bus_valid = (state == REQ);
        cpu_stall = accept || (state == REQ) || (state == WAIT_R);
    end

    // Latch the access fields when a request is accepted; writes win over reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_we    <= 1'b0;
            bus_strb  <= 4'b0000;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            off_q     <= 2'b00;
        end else if (accept) begin
            bus_we    <= |cpu_write;
            bus_strb  <= (|cpu_write) ? cpu_write : 4'b1111;
            bus_addr  <= {cpu_addr[31:2], 2'b00};
            bus_wdata <= cpu_wdata;
            off_q     <= cpu_addr[1:0];
        end
    end

    // Capture aligned read data, or the error pattern when a read is aborted.
    always_ff @(posedge clk) begin
        if (!rst)
            cpu_rdata <= 32'h0;
        else if ((state == WAIT_R) && bus_rvalid)
            cpu_rdata <= lane_align(bus_rdata, off_q);
        else if (abort && !bus_we)
            cpu_rdata <= ERR_DATA;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)
            err <= 1'b0;
        else if (abort)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge. A responder models the bus, the
// driver pushes expected bus requests and core completions into queues,
// and a negedge monitor pops and compares them. A second instance with a
// short watchdog covers the timeout boundaries.
module tb_dmem_bridge;

    typedef struct {
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        int          stall;
        logic [31:0] rdata;
        logic        err;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Main instance signals.
    logic        cpu_read = 1'b0;
    logic [3:0]  cpu_write = 4'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_we;
    logic [3:0]  bus_strb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'hA5A5_A5A5;
    logic        err;

    // Short-watchdog instance signals.
    logic        t_read = 1'b0;
    logic [3:0]  t_write = 4'b0;
    logic [31:0] t_addr = 32'h0;
    logic [31:0] t_wdata = 32'h0;
    logic [31:0] t_rdata;
    logic        t_stall;
    logic        t_bus_valid;
    logic        t_ready = 1'b0;
    logic        t_we;
    logic [3:0]  t_strb;
    logic [31:0] t_baddr;
    logic [31:0] t_bwdata;
    logic        t_err;

    int checks = 0;
    int errors = 0;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    // Responder configuration.
    int          rdy_wait = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_data = 32'h0;

    always #5 clk = ~clk;

    dmem_bridge u_dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_strb   (bus_strb),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .err        (err)
    );

    dmem_bridge #(
        .TIMEOUT_CYCLES (4)
    ) u_dut_to (
        .clk        (clk),
        .rst        (rst),
        .cpu_read   (t_read),
        .cpu_write  (t_write),
        .cpu_addr   (t_addr),
        .cpu_wdata  (t_wdata),
        .cpu_rdata  (t_rdata),
        .cpu_stall  (t_stall),
        .bus_valid  (t_bus_valid),
        .bus_ready  (t_ready),
        .bus_we     (t_we),
        .bus_strb   (t_strb),
        .bus_addr   (t_baddr),
        .bus_wdata  (t_bwdata),
        .bus_rvalid (1'b0),
        .bus_rdata  (32'h0),
        .err        (t_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bus responder: ready after rdy_wait valid cycles, rvalid rsp_wait cycles after a read handshake.
    initial begin
        int  vcnt;
        int  wcnt;
        bit  rd_pend;
        vcnt = 0;
        wcnt = 0;
        rd_pend = 0;
        forever begin
            @(posedge clk);
            #1;
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = 32'hA5A5_A5A5;
            if (rd_pend) begin
                if (wcnt == rsp_wait) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rsp_data;
                    rd_pend    = 0;
                end else begin
                    wcnt++;
                end
            end else if (bus_valid) begin
                if (vcnt == rdy_wait) begin
                    bus_ready = 1'b1;
                    vcnt      = 0;
                    if (!bus_we) begin
                        rd_pend = 1;
                        wcnt    = 0;
                    end
                end else begin
                    vcnt++;
                end
            end else begin
                vcnt = 0;
            end
        end
    end

    // Monitor: compares bus handshakes and core completions against the queues.
    int        stall_cnt = 0;
    bus_exp_t  be;
    done_exp_t de;
    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt = 0;
        end else begin
            if (bus_valid && bus_ready) begin
                check("bus_expected", 32'(bus_q.size() > 0), 32'd1);
                if (bus_q.size() > 0) begin
                    be = bus_q.pop_front();
                    check("bus_we",    32'(bus_we),   32'(be.we));
                    check("bus_strb",  32'(bus_strb), 32'(be.strb));
                    check("bus_addr",  bus_addr,      be.addr);
                    check("bus_wdata", bus_wdata,     be.wdata);
                end
            end
            if (cpu_stall) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                check("done_expected", 32'(done_q.size() > 0), 32'd1);
                if (done_q.size() > 0) begin
                    de = done_q.pop_front();
                    check("stall_cycles",   32'(stall_cnt), 32'(de.stall));
                    check("cpu_rdata",      cpu_rdata,      de.rdata);
                    check("err",            32'(err),       32'(de.err));
                    check("done_bus_valid", 32'(bus_valid), 32'd0);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic issue(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(posedge clk);
        #1;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    task automatic release_cpu();
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 4'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
    endtask

    // Wait (bounded) until the stall drops; returns on the negedge of that cycle.
    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (cpu_stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 32'(cpu_stall), 32'd0);
    endtask

    task automatic push_bus(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bus_exp_t e;
        e.we = we; e.strb = strb; e.addr = addr; e.wdata = wdata;
        bus_q.push_back(e);
    endtask

    task automatic push_done(input int stall, input logic [31:0] rdata, input logic e_err);
        done_exp_t e;
        e.stall = stall; e.rdata = rdata; e.err = e_err;
        done_q.push_back(e);
    endtask

    initial begin
        int n_stall;
        int n_valid;
        int guard;

        // Reset state; stall must follow the IDLE equation even in reset.
        repeat (3) @(posedge clk);
        #1;
        cpu_read = 1'b1;
        @(negedge clk);
        check("rst_stall_req", 32'(cpu_stall), 32'd1);
        cpu_read = 1'b0;
        @(negedge clk);
        check("rst_stall",     32'(cpu_stall), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_we",    32'(bus_we),    32'd0);
        check("rst_bus_strb",  32'(bus_strb),  32'd0);
        check("rst_bus_addr",  bus_addr,       32'd0);
        check("rst_bus_wdata", bus_wdata,      32'd0);
        check("rst_cpu_rdata", cpu_rdata,      32'd0);
        check("rst_err",       32'(err),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Minimum single-byte write.
        rdy_wait = 0;
        push_bus(1'b1, 4'b0100, 32'h0000_0100, 32'h00AB_0000);
        push_done(2, 32'h0, 1'b0);
        issue(1'b0, 4'b0100, 32'h0000_0102, 32'h00AB_0000);
        wait_done();
        release_cpu();

        // Byte read at offset 3 with three wait cycles.
        rsp_wait = 3;
        rsp_data = 32'h8100_0000;
        push_bus(1'b0, 4'b1111, 32'h0000_0200, 32'h0);
        push_done(6, 32'h0000_0081, 1'b0);
        issue(1'b1, 4'b0000, 32'h0000_0203, 32'h0);
        wait_done();
        release_cpu();

        // Request held through DONE: one transaction, then a fresh one after IDLE.
        rsp_wait = 0;
        rsp_data = 32'h1122_3344;
        push_bus(1'b0, 4'b1111, 32'h0000_0010, 32'h0);
        push_done(3, 32'h1122_3344, 1'b0);
        push_bus(1'b0, 4'b1111, 32'h0000_0010, 32'h0);
        push_done(3, 32'h5566_7788, 1'b0);
        issue(1'b1, 4'b0000, 32'h0000_0010, 32'h0);
        wait_done();
        rsp_data = 32'h5566_7788;
        wait_done();
        release_cpu();

        // Read and full write together: write wins, no read phase.
        push_bus(1'b1, 4'b1111, 32'h0000_0300, 32'hCAFE_F00D);
        push_done(2, 32'h5566_7788, 1'b0);
        issue(1'b1, 4'b1111, 32'h0000_0300, 32'hCAFE_F00D);
        wait_done();
        release_cpu();

        // Halfword read at offset 2 with a slow ready.
        rdy_wait = 2;
        rsp_data = 32'hBEEF_1234;
        push_bus(1'b0, 4'b1111, 32'h0000_0410, 32'h0);
        push_done(5, 32'h0000_BEEF, 1'b0);
        issue(1'b1, 4'b0000, 32'h0000_0412, 32'h0);
        wait_done();
        release_cpu();
        rdy_wait = 0;

        // Watchdog instance: handshake in the expiry cycle wins, no error.
        @(posedge clk);
        #1;
        t_write = 4'b0001;
        t_addr  = 32'h0000_0044;
        t_wdata = 32'h0000_005A;
        repeat (4) @(posedge clk);
        #1;
        t_ready = 1'b1;
        @(negedge clk);
        check("to_hs_valid", 32'(t_bus_valid), 32'd1);
        check("to_hs_stall", 32'(t_stall),     32'd1);
        @(posedge clk);
        #1;
        t_ready = 1'b0;
        t_write = 4'b0;
        @(negedge clk);
        check("to_hs_done_stall", 32'(t_stall), 32'd0);
        check("to_hs_err",        32'(t_err),   32'd0);
        check("to_hs_rdata",      t_rdata,      32'd0);

        // Watchdog instance: ready stuck low on a read aborts after 4 REQ cycles.
        @(posedge clk);
        #1;
        t_read = 1'b1;
        t_addr = 32'h0000_0048;
        n_stall = 0;
        n_valid = 0;
        guard   = 0;
        do begin
            @(negedge clk);
            if (t_stall) n_stall++;
            if (t_bus_valid) n_valid++;
            guard++;
        end while (t_stall && guard < 30);
        check("to_stall_cycles", 32'(n_stall),     32'd5);
        check("to_valid_cycles", 32'(n_valid),     32'd4);
        check("to_abort_valid",  32'(t_bus_valid), 32'd0);
        check("to_abort_rdata",  t_rdata,          32'hDEAD_BEEF);
        check("to_abort_err",    32'(t_err),       32'd1);
        @(posedge clk);
        #1;
        t_read = 1'b0;
        repeat (3) @(negedge clk);
        check("to_err_sticky",  32'(t_err), 32'd1);
        check("to_rdata_hold",  t_rdata,    32'hDEAD_BEEF);

        // Reset while in WAIT_R; the late response must be discarded in IDLE.
        rsp_wait = 5;
        rsp_data = 32'h7777_7777;
        push_bus(1'b0, 4'b1111, 32'h0000_0500, 32'h0);
        issue(1'b1, 4'b0000, 32'h0000_0500, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        cpu_read = 1'b0;
        cpu_addr = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rr_stall",     32'(cpu_stall), 32'd0);
        check("rr_bus_valid", 32'(bus_valid), 32'd0);
        check("rr_cpu_rdata", cpu_rdata,      32'd0);
        check("rr_err",       32'(err),       32'd0);
        check("rr_to_err",    32'(t_err),     32'd0);
        check("rr_to_rdata",  t_rdata,        32'd0);

        repeat (2) @(negedge clk);
        check("bus_q_empty",  32'(bus_q.size()),  32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
